// File: rtl/conv_window_feeder.sv
// conv_window_feeder: streams a 16-channel feature map as 5-pixel columns
// into the 5x5xN conv unit and flags each cycle a full window is present.
module conv_window_feeder #(
  parameter int BIT_WIDTH  = 8,
  parameter int IN_W       = 5,
  parameter int IN_H       = 5,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [16*BIT_WIDTH-1:0] mem_rd_data,
  output logic [16*BIT_WIDTH-1:0] in1,
  output logic [16*BIT_WIDTH-1:0] in2,
  output logic [16*BIT_WIDTH-1:0] in3,
  output logic [16*BIT_WIDTH-1:0] in4,
  output logic [16*BIT_WIDTH-1:0] in5,
  output logic                    en,
  output logic                    win_valid,
  output logic [7:0]              win_row,
  output logic [7:0]              win_col,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    PUSH
  } state_t;

  localparam logic [7:0] LAST_COL = 8'(IN_W - 1);
  localparam logic [7:0] LAST_ROW = 8'(IN_H - 5);

  state_t                  state;
  logic [2:0]              k;
  logic [7:0]              row_base;
  logic [7:0]              col;
  logic [16*BIT_WIDTH-1:0] slot [4];

  function automatic logic [ADDR_WIDTH-1:0] addr_of(
    input logic [7:0] r,
    input logic [7:0] c
  );
    return ADDR_WIDTH'(r) * ADDR_WIDTH'(IN_W) + ADDR_WIDTH'(c);
  endfunction

  // Column sequencer: 5 reads, 1 drain, 1 push per column, raster order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      k         <= '0;
      row_base  <= '0;
      col       <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      in1       <= '0;
      in2       <= '0;
      in3       <= '0;
      in4       <= '0;
      in5       <= '0;
      en        <= 1'b0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
    end else begin
      en        <= 1'b0;
      win_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            row_base  <= '0;
            col       <= '0;
            k         <= '0;
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
            mem_addr  <= '0;
          end
        end
        FETCH: begin
          if (k != 3'd0) slot[2'(k - 3'd1)] <= mem_rd_data;
          if (k == 3'd4) begin
            state     <= DRAIN;
            mem_rd_en <= 1'b0;
          end else begin
            k        <= k + 3'd1;
            mem_addr <= addr_of(row_base + 8'(k) + 8'd1, col);
          end
        end
        DRAIN: begin
          in1   <= slot[0];
          in2   <= slot[1];
          in3   <= slot[2];
          in4   <= slot[3];
          in5   <= mem_rd_data;
          en    <= 1'b1;
          state <= PUSH;
        end
        PUSH: begin
          if (col >= 8'd4) begin
            win_valid <= 1'b1;
            win_row   <= row_base;
            win_col   <= col - 8'd4;
          end
          k <= '0;
          if (col < LAST_COL) begin
            col       <= col + 8'd1;
            state     <= FETCH;
            mem_rd_en <= 1'b1;
            mem_addr  <= addr_of(row_base, col + 8'd1);
          end else if (row_base < LAST_ROW) begin
            col       <= '0;
            row_base  <= row_base + 8'd1;
            state     <= FETCH;
            mem_rd_en <= 1'b1;
            mem_addr  <= addr_of(row_base + 8'd1, 8'd0);
          end else begin
            state <= IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
